// File: rtl/adder_scheduler_if.sv
// adder_scheduler_if
// Requester-side bus of the adder scheduler.
//   req       : per-requester request, held until its rsp_valid pulse
//   opa, opb  : packed 8-bit operands, requester i on bits [8i+7:8i]
//   gnt       : one-hot grant, high from issue until the response
//   rsp_valid : one-cycle response pulse to the served requester
//   rsp_data  : sum (a+b mod 256), valid with rsp_valid
//   rsp_err   : pulses with rsp_valid when the operation timed out
// master = requester side, slave = scheduler side.
interface adder_scheduler_if #(
   parameter int unsigned NUM_REQ = 4
) ();
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] opa;
   logic [8*NUM_REQ-1:0] opb;
   logic [NUM_REQ-1:0]   gnt;
   logic [NUM_REQ-1:0]   rsp_valid;
   logic [7:0]           rsp_data;
   logic                 rsp_err;

   modport master (
      output req, opa, opb,
      input  gnt, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req, opa, opb,
      output gnt, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/adder_scheduler.sv
// adder_scheduler
// Round-robin scheduler sharing one serial 8-bit adder among NUM_REQ requesters.
// One operation is outstanding at a time; an operation that gets no add_done
// within TIMEOUT wait cycles is answered with rsp_err and rsp_data = 0.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : requester bus (adder_scheduler_if.slave)
//   busy      : high in every state except idle
//   add_a/b   : operands to the shared adder, held until the next grant
//   add_start : one-cycle adder start strobe
//   add_c     : adder result
//   add_done  : adder done flag, may stay high for several cycles
// All outputs come straight from registers.
module adder_scheduler #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned TIMEOUT = 31
) (
   input  logic             clk,
   input  logic             rst,
   adder_scheduler_if.slave bus,
   output logic             busy,
   output logic [7:0]       add_a,
   output logic [7:0]       add_b,
   output logic             add_start,
   input  logic [7:0]       add_c,
   input  logic             add_done
);
   localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDrain} state_e;

   state_e             state_q, state_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [PW-1:0]      win_q, win_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [7:0]         rsp_data_q, rsp_data_d;
   logic               rsp_err_q, rsp_err_d;
   logic               busy_q, busy_d;
   logic [7:0]         add_a_q, add_a_d;
   logic [7:0]         add_b_q, add_b_d;
   logic               add_start_q, add_start_d;

   logic [7:0]    opa_arr [NUM_REQ];
   logic [7:0]    opb_arr [NUM_REQ];
   logic          found;
   logic [PW-1:0] pick;
   logic [PW-1:0] ptr_next;
   int unsigned   idx;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign opa_arr[g] = bus.opa[8*g +: 8];
      assign opb_arr[g] = bus.opb[8*g +: 8];
   end

   // Round-robin pick: first requester at or above ptr, wrapping around.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = 32'(ptr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && bus.req[PW'(idx)]) begin
            found = 1'b1;
            pick  = PW'(idx);
         end
      end
   end

   assign ptr_next = (32'(win_q) == NUM_REQ - 1) ? '0 : win_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      win_d       = win_q;
      cnt_d       = cnt_q;
      gnt_d       = gnt_q;
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = 1'b0;
      add_a_d     = add_a_q;
      add_b_d     = add_b_q;
      add_start_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            // add_done is deliberately ignored here and in StIssue.
            if (found) begin
               win_d        = pick;
               gnt_d        = '0;
               gnt_d[pick]  = 1'b1;
               add_a_d      = opa_arr[pick];
               add_b_d      = opb_arr[pick];
               add_start_d  = 1'b1;
               state_d      = StIssue;
            end
         end
         StIssue: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            if (add_done) begin
               rsp_valid_d        = '0;
               rsp_valid_d[win_q] = 1'b1;
               rsp_data_d         = add_c;
               gnt_d              = '0;
               ptr_d              = ptr_next;
               state_d            = StDrain;
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
               rsp_valid_d        = '0;
               rsp_valid_d[win_q] = 1'b1;
               rsp_data_d         = '0;
               rsp_err_d          = 1'b1;
               gnt_d              = '0;
               ptr_d              = ptr_next;
               state_d            = StDrain;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StDrain: begin
            // Wait for the adder to drop done before a new start can be issued.
            if (!add_done) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         win_q       <= '0;
         cnt_q       <= '0;
         gnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         add_a_q     <= '0;
         add_b_q     <= '0;
         add_start_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         win_q       <= win_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         add_start_q <= add_start_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   assign busy          = busy_q;
   assign add_a         = add_a_q;
   assign add_b         = add_b_q;
   assign add_start     = add_start_q;
endmodule

// File: tb/tb_adder_scheduler.sv
// tb_adder_scheduler
// Directed bench for adder_scheduler with a behavioural serial adder whose
// latency, done-hold length and liveness are set per test.
module tb_adder_scheduler;
   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned TIMEOUT = 31;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       busy;
   logic [7:0] add_a;
   logic [7:0] add_b;
   logic       add_start;
   logic [7:0] add_c;
   logic       add_done;

   adder_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

   adder_scheduler #(
      .NUM_REQ(NUM_REQ),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .busy     (busy),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_start(add_start),
      .add_c    (add_c),
      .add_done (add_done)
   );

   always #5 clk = ~clk;

   int cyc     = 0;
   int n_start = 0;
   int n_rsp   = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (add_start === 1'b1) n_start <= n_start + 1;
      if (bus.rsp_valid !== '0) n_rsp <= n_rsp + 1;
   end

   // Adder model: start sampled at edge s -> done high from edge s+lat-1 for
   // hold cycles; dead ignores starts; spur forces done high.
   int         lat  = 10;
   int         hold = 1;
   bit         dead = 1'b0;
   bit         spur = 1'b0;
   int         acnt = 0;
   int         hcnt = 0;
   logic       done_r = 1'b0;
   logic [7:0] sum_r  = 8'h00;
   logic [7:0] c_r    = 8'h00;

   assign add_done = done_r | spur;
   assign add_c    = c_r;

   always @(posedge clk) begin
      if (rst) begin
         acnt   <= 0;
         hcnt   <= 0;
         done_r <= 1'b0;
         c_r    <= 8'h00;
      end else begin
         if (done_r) begin
            if (hcnt == 0) done_r <= 1'b0;
            else hcnt <= hcnt - 1;
         end
         if (add_start && !dead) begin
            acnt  <= lat - 1;
            sum_r <= add_a + add_b;
         end else if (acnt > 1) begin
            acnt <= acnt - 1;
         end else if (acnt == 1) begin
            acnt   <= 0;
            done_r <= 1'b1;
            c_r    <= sum_r;
            hcnt   <= hold - 1;
         end
      end
   end

   typedef struct {
      logic [3:0]  req;
      logic [31:0] opa;
      logic [31:0] opb;
      int          lat;
      int          hold;
      bit          dead;
      logic [3:0]  exp_gnt;
      logic [7:0]  exp_a;
      logic [7:0]  exp_b;
      logic [7:0]  exp_data;
      bit          exp_err;
      int          exp_lat;
   } vec_t;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic wait_gnt(output int t);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.gnt === '0 && n < 200);
      t = cyc;
   endtask

   task automatic wait_rsp(output int t);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.rsp_valid === '0 && n < 200);
      t = cyc;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("idle_reached", 32'(busy), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
      chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
      chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_add_a"}, 32'(add_a), 32'd0);
      chk({tag, "_add_b"}, 32'(add_b), 32'd0);
      chk({tag, "_add_start"}, 32'(add_start), 32'd0);
   endtask

   task automatic run_row(input int r, input vec_t v);
      int    tg;
      int    tr;
      string s;
      s    = $sformatf("row%0d", r);
      lat  = v.lat;
      hold = v.hold;
      dead = v.dead;
      bus.req = v.req;
      bus.opa = v.opa;
      bus.opb = v.opb;
      wait_gnt(tg);
      chk({s, "_gnt"}, 32'(bus.gnt), 32'(v.exp_gnt));
      chk({s, "_start"}, 32'(add_start), 32'd1);
      chk({s, "_add_a"}, 32'(add_a), 32'(v.exp_a));
      chk({s, "_add_b"}, 32'(add_b), 32'(v.exp_b));
      chk({s, "_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      chk({s, "_start_off"}, 32'(add_start), 32'd0);
      chk({s, "_a_hold"}, 32'(add_a), 32'(v.exp_a));
      wait_rsp(tr);
      chk({s, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(v.exp_gnt));
      chk({s, "_rsp_data"}, 32'(bus.rsp_data), 32'(v.exp_data));
      chk({s, "_rsp_err"}, 32'(bus.rsp_err), 32'(v.exp_err));
      chk({s, "_latency"}, 32'(tr - tg), 32'(v.exp_lat));
      chk({s, "_gnt_clr"}, 32'(bus.gnt), 32'd0);
      bus.req = '0;
      @(negedge clk);
      chk({s, "_pulse_end"}, 32'({bus.rsp_valid, bus.rsp_err}), 32'd0);
      wait_idle();
      dead = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t       vt [7];
      logic [3:0] ord [5];
      logic [7:0] sums [5];
      int         tg;
      int         tr;
      int         t0;
      int         s0;
      int         r0;

      vt[0] = '{4'b0100, 32'h003C_0000, 32'h0005_0000, 10, 1, 1'b0,
                4'b0100, 8'h3C, 8'h05, 8'h41, 1'b0, 11};
      vt[1] = '{4'b0001, 32'h0000_00FF, 32'h0000_0002, 4, 3, 1'b0,
                4'b0001, 8'hFF, 8'h02, 8'h01, 1'b0, 5};
      vt[2] = '{4'b1001, 32'h8000_0011, 32'h8000_0022, 3, 2, 1'b0,
                4'b1000, 8'h80, 8'h80, 8'h00, 1'b0, 4};
      vt[3] = '{4'b0011, 32'h0000_AA7F, 32'h0000_BB01, 2, 1, 1'b0,
                4'b0001, 8'h7F, 8'h01, 8'h80, 1'b0, 3};
      vt[4] = '{4'b0011, 32'h0000_A5CC, 32'h0000_5ADD, 5, 2, 1'b0,
                4'b0010, 8'hA5, 8'h5A, 8'hFF, 1'b0, 6};
      vt[5] = '{4'b0010, 32'h0000_0100, 32'h0000_0100, 10, 1, 1'b1,
                4'b0010, 8'h01, 8'h01, 8'h00, 1'b1, 1 + TIMEOUT};
      vt[6] = '{4'b0011, 32'h0000_0709, 32'h0000_0608, 2, 4, 1'b0,
                4'b0001, 8'h09, 8'h08, 8'h11, 1'b0, 3};

      ord[0] = 4'b0001; ord[1] = 4'b0010; ord[2] = 4'b0100; ord[3] = 4'b1000;
      ord[4] = 4'b0001;
      sums[0] = 8'h11; sums[1] = 8'h22; sums[2] = 8'h33; sums[3] = 8'h44;
      sums[4] = 8'h11;

      bus.req = '0;
      bus.opa = '0;
      bus.opb = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;

      for (int r = 0; r < 7; r++) run_row(r, vt[r]);

      // add_done high while idle and during issue must not complete the op.
      lat     = 4;
      hold    = 1;
      spur    = 1'b1;
      bus.req = 4'b0001;
      bus.opa = 32'h0000_0021;
      bus.opb = 32'h0000_0021;
      wait_gnt(tg);
      chk("spur_gnt", 32'(bus.gnt), 32'b0001);
      @(negedge clk);
      spur = 1'b0;
      chk("spur_no_rsp", 32'(bus.rsp_valid), 32'd0);
      wait_rsp(tr);
      chk("spur_latency", 32'(tr - tg), 32'd5);
      chk("spur_data", 32'(bus.rsp_data), 32'h42);
      bus.req = '0;
      wait_idle();

      // Requester 3 drops req right after its grant.
      lat     = 6;
      bus.req = 4'b1000;
      bus.opa = 32'hC800_0000;
      bus.opb = 32'h6400_0000;
      wait_gnt(tg);
      chk("drop_gnt", 32'(bus.gnt), 32'b1000);
      @(negedge clk);
      bus.req = '0;
      wait_rsp(tr);
      chk("drop_rsp_valid", 32'(bus.rsp_valid), 32'b1000);
      chk("drop_data", 32'(bus.rsp_data), 32'h2C);
      chk("drop_latency", 32'(tr - tg), 32'd7);
      wait_idle();
      @(negedge clk);
      chk("drop_no_regrant", 32'(bus.gnt), 32'd0);

      // All four requesting continuously from reset.
      rst     = 1'b1;
      lat     = 4;
      hold    = 3;
      bus.req = 4'b1111;
      bus.opa = 32'h4030_2010;
      bus.opb = 32'h0403_0201;
      repeat (2) @(negedge clk);
      chk("rst_over_req_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_over_req_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      s0  = n_start;
      tr  = 0;
      for (int k = 0; k < 5; k++) begin
         wait_gnt(tg);
         chk($sformatf("fair_gnt%0d", k), 32'(bus.gnt), 32'(ord[k]));
         if (k > 0) chk($sformatf("fair_gap%0d", k), 32'(tg - tr), 32'(hold + 1));
         wait_rsp(tr);
         chk($sformatf("fair_rsp%0d", k), 32'(bus.rsp_valid), 32'(ord[k]));
         chk($sformatf("fair_data%0d", k), 32'(bus.rsp_data), 32'(sums[k]));
      end
      chk("fair_start_count", 32'(n_start - s0), 32'd5);

      // Reset while requester 1 is in its wait phase.
      lat     = 10;
      hold    = 1;
      bus.req = 4'b0010;
      wait_gnt(tg);
      chk("rstw_gnt", 32'(bus.gnt), 32'b0010);
      repeat (3) @(negedge clk);
      chk("rstw_busy", 32'(busy), 32'd1);
      r0  = n_rsp;
      rst = 1'b1;
      @(negedge clk);
      chk_all_zero("rstw");
      rst = 1'b0;
      t0  = cyc;
      wait_gnt(tg);
      chk("rstw_regrant", 32'(bus.gnt), 32'b0010);
      chk("rstw_regrant_delay", 32'(tg - t0), 32'd1);
      chk("rstw_no_pulse", 32'(n_rsp - r0), 32'd0);
      wait_rsp(tr);
      chk("rstw_rsp_valid", 32'(bus.rsp_valid), 32'b0010);
      chk("rstw_data", 32'(bus.rsp_data), 32'h22);
      bus.req = '0;
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/adder_scheduler.md
ADDER_SCHEDULER -- requirements
Module: adder_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requester ports, range 2..8.
REQ-002 Parameter TIMEOUT, default 31: maximum WAIT cycles before an operation is aborted, range 12..255.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req  in  NUM_REQ  per-requester request; held high until the matching rsp_valid.
REQ-006 opa  in  8*NUM_REQ  operand A; requester i drives bits [8i+7:8i]; stable while req[i] high.
REQ-007 opb  in  8*NUM_REQ  operand B; same packing as opa.
REQ-008 gnt  out  NUM_REQ  one-hot grant; high from ISSUE entry until response.
REQ-009 rsp_valid  out  NUM_REQ  one-cycle response pulse to the served requester.
REQ-010 rsp_data  out  8  sum (a+b mod 256); valid while any rsp_valid bit is high.
REQ-011 rsp_err  out  1  one-cycle pulse coincident with rsp_valid when the operation timed out.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 add_a, add_b  out  8 each  operands to the shared serial adder.
REQ-014 add_start  out  1  adder start strobe.
REQ-015 add_c  in  8  adder result.
REQ-016 add_done  in  1  adder done flag; may stay high for more than one cycle.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, DRAIN.
REQ-019 In IDLE with any req bit high at edge t:
- winner is selected round-robin, searching upward from pointer ptr with wrap-around;
- at edge t the block loads gnt = one-hot winner, add_a/add_b = winner's operands, add_start = 1;
- state goes to ISSUE.
REQ-020 ISSUE SHALL last exactly one cycle; at edge t+1 add_start=0 and state goes to WAIT, so add_start is high for exactly one cycle with add_a/add_b stable.
REQ-021 add_a/add_b SHALL hold their values until the next grant.
REQ-022 In WAIT, the first sampled add_done=1 SHALL cause, at that edge:
- rsp_data=add_c, rsp_valid[winner]=1, gnt=0;
- ptr=(winner+1) mod NUM_REQ;
- state goes to DRAIN.
REQ-023 A WAIT cycle counter SHALL clear on WAIT entry; if it reaches TIMEOUT without add_done, at that edge:
- rsp_valid[winner]=1, rsp_data=0, rsp_err=1, gnt=0;
- ptr advances as in REQ-022;
- state goes to DRAIN.
REQ-024 rsp_valid and rsp_err SHALL clear on the edge after they were set.
REQ-025 DRAIN SHALL remain until add_done is sampled 0, then go to IDLE; no add_start is issued in DRAIN. This guarantees the adder is back in its idle state before the next start.
REQ-026 A requester that deasserts req mid-operation SHALL still receive its rsp_valid pulse; the operation is never cancelled.
REQ-027 A req bit still high when IDLE is re-entered SHALL be treated as a new request.
REQ-028 Requests arriving outside IDLE SHALL wait; no request is lost while held.
REQ-029 Exactly one operation SHALL be outstanding at any time; gnt and rsp_valid are each at most one-hot.
REQ-030 add_done=1 sampled in IDLE or ISSUE SHALL be ignored.

Reset
REQ-031 With rst=1 at an edge, the block SHALL set:
- state=IDLE, ptr=0, WAIT counter=0;
- gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0;
- add_a=0, add_b=0, add_start=0.
REQ-032 rst SHALL take priority over every other event; it overrides req on the same edge.
REQ-033 Reset mid-operation SHALL abandon the operation with no rsp_valid pulse; the adder shares the same rst.

Verification
REQ-034 Single request: req[2]=1, opa=0x3C, opb=0x05 -> gnt=0b0100, one add_start pulse, add_a=0x3C, add_b=0x05; then rsp_valid=0b0100 with rsp_data=0x41, rsp_err=0; a 10-cycle adder gives rsp_valid 11 cycles after the grant edge.
REQ-035 Overflow: opa=0xFF, opb=0x02 -> rsp_data=0x01.
REQ-036 Fairness: req=0b1111 held continuously from reset -> service order 0,1,2,3,0; no add_start while busy; a new grant only after add_done is sampled low.
REQ-037 Timeout: add_done tied 0 -> TIMEOUT cycles after WAIT entry, rsp_valid pulses with rsp_data=0x00 and rsp_err=1, then FSM returns to IDLE.
REQ-038 Reset mid-WAIT: rst pulsed during WAIT with req[1] held -> no rsp_valid, all outputs 0; after release, req[1] is granted first (ptr=0 search reaches 1).
REQ-039 Early drop: req[3] deasserted the cycle after grant -> rsp_valid[3] still pulses with the correct sum.
